// File: rtl/mac_psum_accum.sv
// Partial-sum accumulator behind the dual-product MAC array: sums both product
// streams of every lane over an in_last-framed group and presents the totals.
module mac_psum_accum #(
    parameter int N     = 144,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [16*N-1:0]    prod1,
    input  logic [16*N-1:0]    prod2,
    output logic [ACC_W*N-1:0] acc1,
    output logic [ACC_W*N-1:0] acc2,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic               ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [ACC_W-1:0] sext16(input logic [15:0] p);
        return {{(ACC_W-16){p[15]}}, p};
    endfunction

    // Two's-complement add overflow from operand and result sign bits.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [ACC_W*N-1:0] wacc1_r, wacc2_r;
    logic [ACC_W*N-1:0] acc1_r, acc2_r;
    logic [CNT_W-1:0]   wcnt_r, beat_cnt_r;
    logic               first_r, wovf_r, ovf_r, out_valid_r;

    logic [ACC_W*N-1:0] sum1_s, sum2_s;
    logic               ovf_any_s, ovf_next_s, accept_s;
    logic [CNT_W-1:0]   cnt_next_s;

    assign in_ready  = ~out_valid_r | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign acc1      = acc1_r;
    assign acc2      = acc2_r;
    assign beat_cnt  = beat_cnt_r;
    assign ovf       = ovf_r;
    assign out_valid = out_valid_r;

    // Per-lane sums: on a group's first beat the running sum is treated as zero.
    always_comb begin
        sum1_s    = {(ACC_W*N){1'b0}};
        sum2_s    = {(ACC_W*N){1'b0}};
        ovf_any_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum1_s[ACC_W*i +: ACC_W] = (first_r ? {ACC_W{1'b0}} : wacc1_r[ACC_W*i +: ACC_W])
                                       + sext16(prod1[16*i +: 16]);
            sum2_s[ACC_W*i +: ACC_W] = (first_r ? {ACC_W{1'b0}} : wacc2_r[ACC_W*i +: ACC_W])
                                       + sext16(prod2[16*i +: 16]);
            if (!first_r) begin
                ovf_any_s = ovf_any_s
                          | add_ovf(wacc1_r[ACC_W*i+ACC_W-1], prod1[16*i+15], sum1_s[ACC_W*i+ACC_W-1])
                          | add_ovf(wacc2_r[ACC_W*i+ACC_W-1], prod2[16*i+15], sum2_s[ACC_W*i+ACC_W-1]);
            end else begin
                ovf_any_s = ovf_any_s;
            end
        end
    end

    // Saturating beat count and sticky overflow for the beat being accepted.
    always_comb begin
        cnt_next_s = CNT_ONE;
        if (first_r) begin
            cnt_next_s = CNT_ONE;
        end else if (wcnt_r == CNT_MAX) begin
            cnt_next_s = wcnt_r;
        end else begin
            cnt_next_s = wcnt_r + CNT_ONE;
        end
        ovf_next_s = ~first_r & (wovf_r | ovf_any_s);
    end

    // Working accumulators; a last beat re-arms the first-beat flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wacc1_r <= {(ACC_W*N){1'b0}};
            wacc2_r <= {(ACC_W*N){1'b0}};
            wcnt_r  <= {CNT_W{1'b0}};
            wovf_r  <= 1'b0;
            first_r <= 1'b1;
        end else if (accept_s) begin
            wacc1_r <= sum1_s;
            wacc2_r <= sum2_s;
            wcnt_r  <= cnt_next_s;
            wovf_r  <= ovf_next_s;
            first_r <= in_last;
        end
    end

    // Output registers: reload on a last-beat accept, otherwise drain on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1_r      <= {(ACC_W*N){1'b0}};
            acc2_r      <= {(ACC_W*N){1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s && in_last) begin
            acc1_r      <= sum1_s;
            acc2_r      <= sum2_s;
            beat_cnt_r  <= cnt_next_s;
            ovf_r       <= ovf_next_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: doc/mac_psum_accum.md
Name: mac_psum_accum

Overview:
- Downstream stage of the parallel dual-product MAC array. Consumes N lanes × 2 signed 16-bit products per beat (out1/out2 of each lane) and accumulates each product stream over a framed group of beats (in_last marks the final beat).
- Presents 2N accumulated partial sums through a registered valid/ready output with back-pressure.
- Tracks per-group beat count and signed overflow.

Parameters:
- N, 144, lane count; must match the MAC array width.
- ACC_W, 32, accumulator width per stream per lane (≥17).
- CNT_W, 16, width of the group beat counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product beat present.
- in_last  in  1  qualifies the final beat of a group; ignored unless in_valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- prod1  in  16*N  lane i at [16*i+15:16*i], signed.
- prod2  in  16*N  same layout as prod1, signed.
- acc1  out  ACC_W*N  lane i at [ACC_W*i+ACC_W-1:ACC_W*i], registered.
- acc2  out  ACC_W*N  same layout as acc1, registered.
- beat_cnt  out  CNT_W  number of beats in the presented group, saturating.
- ovf  out  1  any lane/stream of the presented group overflowed.
- out_valid  out  1  acc1/acc2/beat_cnt/ovf valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync release):
  - Working accumulators = 0, first-beat flag = 1, working count = 0, working ovf = 0.
  - acc1, acc2, beat_cnt = 0; ovf = 0; out_valid = 0.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Beats must not be dropped: while in_ready = 0, in_valid is held and no state changes. The upstream controller gates the MAC array pipeline on in_ready.
- Accept, first beat of group (first-beat flag = 1):
  - wacc = sign_extend(prod) for each of the 2N streams.
  - wcnt = 1; wovf = 0.
- Accept, subsequent beat:
  - wacc = wacc + sign_extend(prod), modulo 2^ACC_W (wraps, no saturation).
  - wovf |= signed overflow of any addition (operand signs equal, result sign differs).
  - wcnt = wcnt + 1, saturating at 2^CNT_W−1.
- Accept with in_last:
  - Final sums (including this beat), count and ovf are written to the output registers at the same edge.
  - out_valid = 1 from the next cycle; first-beat flag set to 1.
  - Latency: last beat accepted at edge t → results visible and out_valid = 1 after edge t.
- Output hold: acc1/acc2/beat_cnt/ovf are stable while out_valid & ~out_ready.
- Output release:
  - out_valid & out_ready with no new last-beat load → out_valid = 0 next cycle.
  - Same edge as a new last-beat accept → output registers reload with the new group and out_valid stays 1 (back-to-back groups, no bubble).
- Accumulation overlaps output wait: non-last beats of the next group are accepted while out_valid = 1 only when in_ready = 1 (i.e. out_ready = 1). No separate double buffer is required.
- Single-beat group (first & last) → output = sign_extend(prod), beat_cnt = 1, ovf = 0.
- in_last without in_valid: ignored.
- Reset mid-group discards the partial sum. Reset while out_valid = 1 discards the pending result.
- State view: IDLE (flag = 1, out_valid = 0) → ACCUM (flag = 0) → PRESENT (out_valid = 1). PRESENT → ACCUM/IDLE on handshake; ACCUM may coexist with PRESENT.
- All N lanes are independent and identical; no cross-lane arithmetic.

Test Plan:
- Bench parameters: N=4, ACC_W=20, CNT_W=4.
- Reset then idle: out_valid=0, in_ready=1, acc1=acc2=0, beat_cnt=0, ovf=0.
- 3-beat group, all lanes prod1 = 100, −50, 7 and prod2 = −1 each beat, out_ready=1:
  - One cycle after the last beat: acc1 lanes = 57, acc2 lanes = −3 (0xFFFFD), beat_cnt = 3, ovf = 0.
  - out_valid high for exactly 1 cycle.
- Overflow: 17 beats of prod1 = 32767 on lane 0 (ACC_W=20):
  - acc1 lane0 = 557039 mod 2^20 interpreted signed (wraps), ovf = 1.
  - beat_cnt saturates at 15; other lanes unaffected.
- Back-pressure: out_ready=0 after group A (single beat, prod1 = 5):
  - in_ready = 0, the next group's beats are held, and acc1 stays 5.
  - Raise out_ready → A accepted and B accumulates. B's sum excludes no beat and is not double-counted.
- Back-to-back single-beat groups, prod1 = 1, 2, 3 on consecutive cycles, out_ready=1: out_valid stays high 3 cycles, acc1 = 1, 2, 3.
- Assert rst mid-group after 2 beats (prod1 = 9 each), release, send a 1-beat group with prod1 = 4: output acc1 = 4, beat_cnt = 1.
